// File: rtl/pmem_burst_responder.sv
// -----------------------------------------------------------------------------
// pmem_burst_responder
//
// Physical-memory responder for the 64-bit burst side of the cacheline
// interface. Accepts line-aligned read/write requests. After LATENCY cycles it
// answers every request with four 64-bit beats qualified by mem_resp_o. The
// backing store is an internal array of 256-bit lines, kept as 64-bit words so
// that writes update a line one beat at a time.
//
// Parameters:
//   LATENCY      cycles from request acceptance to first beat (1..255)
//   DEPTH_LINES  number of 256-bit lines (power of two)
//   ADDR_W       width of mem_address_i
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   mem_address_i  byte address of the line, bits [4:0] ignored, upper bits alias
//   mem_read_i     read request, held until the final beat
//   mem_write_i    write request, held until the final beat
//   mem_wdata_i    write beat, advanced by the controller after each resp edge
//   mem_rdata_o    read beat, valid while mem_resp_o=1 on a read
//   mem_resp_o     beat strobe, high for four beat cycles per request
//   proto_err_o    sticky protocol-violation flag, cleared only by rst
//
// Optional feature (macro PMEM_BEAT_GAP_EN): when defined, a one-cycle bubble
// (mem_resp_o=0, mem_rdata_o held) is inserted between beat 1 and beat 2.
// -----------------------------------------------------------------------------
module pmem_burst_responder #(
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned DEPTH_LINES = 256,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_address_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [63:0]       mem_wdata_i,
    output logic [63:0]       mem_rdata_o,
    output logic              mem_resp_o,
    output logic              proto_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
    localparam int unsigned WORDS = DEPTH_LINES * 4;
    localparam logic [7:0]  LAT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_BURST   = 2'd2,
        S_RECOVER = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               op_wr_q, op_wr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         beat_q, beat_d;
    logic [7:0]         lat_q, lat_d;
    logic               resp_q, resp_d;
    logic [63:0]        rdata_q, rdata_d;
    logic               perr_q, perr_d;
    logic               req_s;
    logic               wr_en_s;
    logic               unused_s;

    // Backing store: zero at time zero, never reset so contents survive rst.
    logic [63:0] mem_q [0:WORDS-1] = '{default: 64'd0};

    assign req_s    = mem_read_i | mem_write_i;
    // Writes capture mem_wdata_i on the edge that closes each strobed beat.
    assign wr_en_s  = (state_q == S_BURST) && resp_q && op_wr_q;
    assign unused_s = ^{mem_address_i[4:0], mem_address_i[ADDR_W-1:5+IDX_W]};

    assign mem_rdata_o = rdata_q;
    assign mem_resp_o  = resp_q;
    assign proto_err_o = perr_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_s) state_d = S_WAIT;
                else       state_d = S_IDLE;
            end
            S_WAIT: begin
                if (lat_q == 8'd0) state_d = S_BURST;
                else               state_d = S_WAIT;
            end
            S_BURST: begin
                if (resp_q && (beat_q == 2'd3)) state_d = S_RECOVER;
                else                            state_d = S_BURST;
            end
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output and datapath next-values (registered below).
    always_comb begin
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        resp_d  = resp_q;
        rdata_d = rdata_q;
        perr_d  = perr_q;
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    // A simultaneous read+write is served as a read.
                    op_wr_d = ~mem_read_i;
                    idx_d   = mem_address_i[5 +: IDX_W];
                    beat_d  = 2'd0;
                    lat_d   = LAT_LOAD;
                    if (mem_read_i && mem_write_i) perr_d = 1'b1;
                    else                           perr_d = perr_q;
                end else begin
                    resp_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (!req_s) perr_d = 1'b1;
                else        perr_d = perr_q;
                if (lat_q == 8'd0) begin
                    resp_d = 1'b1;
                    beat_d = 2'd0;
                    if (!op_wr_q) rdata_d = mem_q[{idx_q, 2'd0}];
                    else          rdata_d = rdata_q;
                end else begin
                    lat_d = 8'(lat_q - 8'd1);
                end
            end
            S_BURST: begin
                if (!req_s) perr_d = 1'b1;
                else        perr_d = perr_q;
`ifdef PMEM_BEAT_GAP_EN
                if (!resp_q) begin
                    // Leaving the bubble: present beat 2 (beat_q already 2).
                    resp_d = 1'b1;
                    if (!op_wr_q) rdata_d = mem_q[{idx_q, beat_q}];
                    else          rdata_d = rdata_q;
                end else if (beat_q == 2'd1) begin
                    // Enter the bubble; rdata held, nothing captured next edge.
                    resp_d = 1'b0;
                    beat_d = 2'd2;
                end else if (beat_q == 2'd3) begin
                    resp_d  = 1'b0;
                    rdata_d = 64'd0;
                end else begin
                    beat_d = beat_q + 2'd1;
                    if (!op_wr_q) rdata_d = mem_q[{idx_q, beat_q + 2'd1}];
                    else          rdata_d = rdata_q;
                end
`else
                if (beat_q == 2'd3) begin
                    resp_d  = 1'b0;
                    rdata_d = 64'd0;
                end else begin
                    beat_d = beat_q + 2'd1;
                    if (!op_wr_q) rdata_d = mem_q[{idx_q, beat_q + 2'd1}];
                    else          rdata_d = rdata_q;
                end
`endif
            end
            S_RECOVER: begin
                // Requests are ignored here so a held request cannot retrigger.
                resp_d  = 1'b0;
                rdata_d = 64'd0;
            end
            default: begin
                resp_d  = 1'b0;
                rdata_d = 64'd0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            beat_q  <= 2'd0;
            lat_q   <= 8'd0;
            resp_q  <= 1'b0;
            rdata_q <= 64'd0;
            perr_q  <= 1'b0;
        end else begin
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    // Beat-wise line update; the array itself is not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[{idx_q, beat_q}] <= mem_wdata_i;
        end
    end

endmodule

// File: tb/tb_pmem_burst_responder.sv
// -----------------------------------------------------------------------------
// tb_pmem_burst_responder
//
// Directed, self-checking bench for pmem_burst_responder with LATENCY=4,
// DEPTH_LINES=256, ADDR_W=32. Inputs are driven 1 ns after a rising edge and
// outputs sampled at the same point. Builds with or without PMEM_BEAT_GAP_EN.
// -----------------------------------------------------------------------------
module tb_pmem_burst_responder;

    localparam int L = 4;
`ifdef PMEM_BEAT_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_address = 32'd0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [63:0] mem_wdata = 64'd0;
    logic [63:0] mem_rdata;
    logic        mem_resp;
    logic        proto_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] rd [4];
    int          beat_edge [4];
    logic [63:0] bw [4];
    int          k;
    int          n;

    always #5 clk = ~clk;

    pmem_burst_responder #(
        .LATENCY     (L),
        .DEPTH_LINES (256),
        .ADDR_W      (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_address_i (mem_address),
        .mem_read_i    (mem_read),
        .mem_write_i   (mem_write),
        .mem_wdata_i   (mem_wdata),
        .mem_rdata_o   (mem_rdata),
        .mem_resp_o    (mem_resp),
        .proto_err_o   (proto_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request; returns with the DUT back in IDLE.
    task automatic burst(input logic [31:0] addr, input logic rd_en, input logic wr_en,
                         input logic [63:0] w0, input logic [63:0] w1,
                         input logic [63:0] w2, input logic [63:0] w3,
                         input bit hold, input string tag);
        logic [63:0] w [4];
        int kk;
        int nn;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        kk = 0;
        nn = 0;
        mem_address = addr;
        mem_read    = rd_en;
        mem_write   = wr_en;
        mem_wdata   = w0;
        @(posedge clk); #1;
        while (kk < 4 && nn < 60) begin
            if (mem_resp) begin
                beat_edge[kk] = nn;
                rd[kk]        = mem_rdata;
                mem_wdata     = w[kk];
                kk++;
            end
            @(posedge clk); #1;
            nn++;
        end
        check({tag, " beat count"}, 64'(kk), 64'd4);
        check({tag, " resp low after beat 3"}, {63'd0, mem_resp}, 64'd0);
        check({tag, " first beat edge"}, 64'(beat_edge[0]), 64'(L));
        @(posedge clk); #1;
        if (!hold) begin
            check({tag, " rdata zero in recover"}, mem_rdata, 64'd0);
        end
        if (hold) begin
            check({tag, " no resp while held"}, {63'd0, mem_resp}, 64'd0);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                          input logic [63:0] e2, input logic [63:0] e3);
        check({tag, " beat0"}, rd[0], e0);
        check({tag, " beat1"}, rd[1], e1);
        check({tag, " beat2"}, rd[2], e2);
        check({tag, " beat3"}, rd[3], e3);
    endtask

    task automatic idle_chk(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check({tag, " resp"}, {63'd0, mem_resp}, 64'd0);
            check({tag, " rdata"}, mem_rdata, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, then 10 idle cycles.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle_chk(10, "reset idle");
        check("reset proto_err", {63'd0, proto_err}, 64'd0);

        // Write line 2 (0x40), then read it back in order.
        burst(32'h0000_0040, 1'b0, 1'b1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 1'b0, "wr40");
        check("wr40 proto_err", {63'd0, proto_err}, 64'd0);
        burst(32'h0000_0040, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, "rd40");
        chk_rd("rd40", 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        check("rd40 beat2 edge", 64'(beat_edge[2]), 64'(L + 2 + GAP));
        check("rd40 beat3 edge", 64'(beat_edge[3]), 64'(L + 3 + GAP));

        // Neighbour line 3 (0x60) must not disturb line 2.
        burst(32'h0000_0060, 1'b0, 1'b1, 64'h5555_0000_0000_0005, 64'h6666_0000_0000_0006,
              64'h7777_0000_0000_0007, 64'h8888_0000_0000_0008, 1'b0, "wr60");
        burst(32'h0000_2040, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, "rd2040 alias");
        chk_rd("rd2040 alias", 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        burst(32'h0000_005F, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, "rd5f lowbits");
        chk_rd("rd5f lowbits", 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        burst(32'h0000_0060, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, "rd60");
        chk_rd("rd60", 64'h5555_0000_0000_0005, 64'h6666_0000_0000_0006,
               64'h7777_0000_0000_0007, 64'h8888_0000_0000_0008);

        // Request held one cycle past beat 3 must not retrigger.
        mem_read = 1'b0;
        burst(32'h0000_0060, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, "hold");
        idle_chk(L + 3, "no retrigger");

        // Held request, then a new read right after RECOVER is accepted.
        burst(32'h0000_0040, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, "hold2");
        burst(32'h0000_0060, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, "b2b");
        chk_rd("b2b", 64'h5555_0000_0000_0005, 64'h6666_0000_0000_0006,
               64'h7777_0000_0000_0007, 64'h8888_0000_0000_0008);
        check("b2b proto_err", {63'd0, proto_err}, 64'd0);

        // Read and write together: served as a read, array untouched, sticky error.
        burst(32'h0000_0080, 1'b0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
              64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD, 1'b0, "wr80");
        burst(32'h0000_0080, 1'b1, 1'b1, 64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001,
              64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0003, 1'b0, "rdwr80");
        chk_rd("rdwr80", 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
               64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);
        check("rdwr80 proto_err", {63'd0, proto_err}, 64'd1);
        burst(32'h0000_0080, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, "rd80");
        chk_rd("rd80", 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
               64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);
        check("rd80 proto_err sticky", {63'd0, proto_err}, 64'd1);

        // Reset during beat 2 of a write: beats 0-1 new, 2-3 old.
        burst(32'h0000_0100, 1'b0, 1'b1, 64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1,
              64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3, 1'b0, "wr100 old");
        bw[0] = 64'hB0B0_B0B0_B0B0_B0B0;
        bw[1] = 64'hB1B1_B1B1_B1B1_B1B1;
        bw[2] = 64'hB2B2_B2B2_B2B2_B2B2;
        bw[3] = 64'hB3B3_B3B3_B3B3_B3B3;
        k = 0;
        n = 0;
        mem_address = 32'h0000_0100;
        mem_write   = 1'b1;
        mem_wdata   = bw[0];
        @(posedge clk); #1;
        while (k < 3 && n < 60) begin
            if (mem_resp) begin
                mem_wdata = bw[k];
                k++;
            end
            if (k < 3) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("rst mid reached beat2", 64'(k), 64'd3);
        check("rst mid beat2 edge", 64'(n), 64'(L + 2 + GAP));
        #2 rst = 1'b1;
        #1;
        check("rst mid resp", {63'd0, mem_resp}, 64'd0);
        check("rst mid rdata", mem_rdata, 64'd0);
        check("rst mid proto_err", {63'd0, proto_err}, 64'd0);
        mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        burst(32'h0000_0100, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, "rd100");
        chk_rd("rd100", 64'hB0B0_B0B0_B0B0_B0B0, 64'hB1B1_B1B1_B1B1_B1B1,
               64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
